// File: rtl/seq_tx.sv
// rtl/seq_tx.sv - serial bit-sequence transmitter, LSB first, with repeat count, inter-word gap and hold stall
module seq_tx #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 4,
  parameter int IDX_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seq_in,
  input  logic [CNT_W-1:0] reps,
  input  logic             hold,
  output logic             ready,
  output logic             sout,
  output logic             sout_vld,
  output logic [IDX_W-1:0] bit_idx,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SEND = 2'b01,
    S_GAP  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               sout_q, sout_d;
  logic               vld_q, vld_d;
  logic               done_q, done_d;

  // The word rotates once per transferred bit, so word_q[1] is always the next
  // bit and a full word of rotations restores the pattern for the next repeat.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    sout_d  = sout_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        sout_d = 1'b0;
        vld_d  = 1'b0;
        if (start) begin
          word_d  = seq_in;
          rep_d   = (reps == '0) ? CNT_W'(1) : reps;
          sout_d  = seq_in[0];
          vld_d   = 1'b1;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!hold) begin
          word_d = {word_q[0], word_q[WIDTH-1:1]};
          if (idx_q != LAST_IDX) begin
            idx_d  = idx_q + IDX_W'(1);
            sout_d = word_q[1];
          end else if (rep_q == CNT_W'(1)) begin
            state_d = S_DONE;
            vld_d   = 1'b0;
            sout_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            rep_d = rep_q - CNT_W'(1);
            if (GAP > 0) begin
              state_d = S_GAP;
              vld_d   = 1'b0;
              sout_d  = 1'b0;
              gap_d   = GAP_LOAD;
            end else begin
              idx_d  = '0;
              sout_d = word_q[1];
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          sout_d  = word_q[0];
          vld_d   = 1'b1;
          idx_d   = '0;
          state_d = S_SEND;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      sout_q  <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      sout_q  <= sout_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign sout     = sout_q;
  assign sout_vld = vld_q;
  assign bit_idx  = idx_q;
  assign done     = done_q;
  assign state    = state_q;

endmodule

// File: tb/tb_seq_tx.sv
// tb/tb_seq_tx.sv - scoreboard bench for seq_tx: directed plan cases plus randomized words, reps, hold and start
module tb_seq_tx;
  localparam int W   = 12;
  localparam int GAP = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] seq_in = '0;
  logic [3:0]  reps = '0;
  logic        hold = 1'b0;
  logic        ready, sout, sout_vld, done;
  logic [3:0]  bit_idx;
  logic [1:0]  state;

  seq_tx #(.WIDTH(W), .CNT_W(4), .IDX_W(4), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .seq_in(seq_in), .reps(reps), .hold(hold),
    .ready(ready), .sout(sout), .sout_vld(sout_vld), .bit_idx(bit_idx), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    bit val;
    int idx;
    int gap;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int idle_run = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: every repetition is the whole word LSB first; repeats after the
  // first are preceded by exactly GAP idle cycles; done follows the last bit.
  function automatic void push_model(input logic [11:0] w, input int r);
    int n;
    exp_t e;
    n = (r == 0) ? 1 : r;
    for (int rep = 0; rep < n; rep++) begin
      for (int b = 0; b < W; b++) begin
        e.is_done = 1'b0;
        e.val = w[b];
        e.idx = b;
        e.gap = (b != 0) ? 0 : ((rep == 0) ? -1 : GAP);
        q.push_back(e);
      end
    end
    e.is_done = 1'b1;
    e.val = 1'b0;
    e.idx = 0;
    e.gap = 0;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (sout_vld && !hold) begin
        if (q.size() == 0) begin
          chk("unexpected_bit", 1, 0);
        end else begin
          e = q.pop_front();
          chk("bit_not_done", int'(e.is_done), 0);
          chk("sout", int'(sout), int'(e.val));
          chk("bit_idx", int'(bit_idx), e.idx);
          if (e.gap >= 0) chk("gap_len", idle_run, e.gap);
        end
        idle_run = 0;
      end else if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_order", int'(e.is_done), 1);
          chk("done_gap", idle_run, 0);
        end
        chk("done_vld_low", int'(sout_vld), 0);
        idle_run = 0;
      end else if (!sout_vld) begin
        idle_run++;
      end
    end
  end

  task automatic transfer(input logic [11:0] w, input logic [3:0] r, input bit rnd,
                          input int stall_at, input int stall_len, output int done_k);
    push_model(w, int'(r));
    @(posedge clk); #1;
    seq_in = w; reps = r; start = 1'b1; hold = 1'b0;
    @(posedge clk); #1;
    seq_in = 12'($urandom); reps = 4'($urandom);
    done_k = -1;
    for (int k = 0; k < 400; k++) begin
      hold  = (k >= stall_at && k < stall_at + stall_len) || (rnd && $urandom_range(3) == 0);
      start = rnd ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
      if (stall_len > 0 && k > stall_at && k <= stall_at + stall_len) begin
        chk("stall_idx", int'(bit_idx), stall_at);
        chk("stall_vld", int'(sout_vld), 1);
        chk("stall_sout", int'(sout), int'(w[stall_at]));
      end
      if (done) begin
        done_k = k;
        chk("done_state", int'(state), 3);
        chk("done_ready", int'(ready), 0);
        break;
      end
      @(posedge clk); #1;
    end
    if (done_k < 0) chk("done_timeout", 1, 0);
    @(posedge clk); #1;
    start = 1'b0; hold = 1'b0;
    @(negedge clk);
    chk("ready_after_done", int'(ready), 1);
    chk("idle_state", int'(state), 0);
  endtask

  initial begin
    int dk;
    rst = 1'b0; start = 1'b1; hold = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_state", int'(state), 0);
    chk("rst_vld", int'(sout_vld), 0);
    chk("rst_sout", int'(sout), 0);
    chk("rst_idx", int'(bit_idx), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; hold = 1'b0;

    transfer(12'hF69, 4'd1, 1'b0, -10, 0, dk);
    chk("lat_single", dk, W);
    transfer(12'hA5C, 4'd3, 1'b0, -10, 0, dk);
    chk("lat_rep3", dk, 3 * W + 2 * GAP);
    transfer(12'h3C7, 4'd1, 1'b0, 5, 3, dk);
    chk("lat_stall", dk, W + 3);
    transfer(12'h5A3, 4'd0, 1'b0, -10, 0, dk);
    chk("lat_reps0", dk, W);

    // Abort at bit 7: queue is flushed because the remaining bits must never appear.
    push_model(12'hABC, 2);
    @(posedge clk); #1;
    seq_in = 12'hABC; reps = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
    end
    chk("abort_idx", int'(bit_idx), 7);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("abort_state", int'(state), 0);
    chk("abort_vld", int'(sout_vld), 0);
    chk("abort_ready", int'(ready), 1);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
    end
    transfer(12'h001, 4'd1, 1'b0, -10, 0, dk);
    chk("lat_after_abort", dk, W);

    for (int t = 0; t < 10; t++) begin
      transfer(12'($urandom), 4'($urandom_range(0, 3)), 1'b1, -10, 0, dk);
    end
    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
